te_state_xfer_ctrl: RTL and testbench

Parametrised fill/dump sequencer for the tracking engine's channel state buffer. On a fill or dump request it walks every physical correlator channel, skips disabled ones, and streams a contiguous word range of each enabled channel's logic-channel state block. Fill reads the buffer and dump writes it. It adds a buffer stall handshake, an abort, and a busy flag. It sits between the tracking-engine sequencer (start/done) and the state buffer RAM port (rd/wr/addr).

---
 rtl/te_state_xfer_ctrl_if.sv | 44 ++++
 rtl/te_state_xfer_ctrl.sv | 135 +++++++++++++
 tb/tb_te_state_xfer_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/te_state_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : te_state_xfer_ctrl_if
// Description : Sequencer-side control and state-buffer port bundle for the
//               channel state fill/dump sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface te_state_xfer_ctrl_if #(
    parameter int PHY_CH     = 4,
    parameter int CH_IDX_W   = 2,
    parameter int LOGIC_CH_W = 5,
    parameter int WORD_W     = 5
);
    logic [PHY_CH-1:0]              physical_channel_en;
    logic [PHY_CH*LOGIC_CH_W-1:0]   logic_channel_index;
    logic                           fill_start;
    logic                           dump_start;
    logic                           abort;
    logic                           state_ready;
    logic [CH_IDX_W-1:0]            physical_channel_index;
    logic                           busy;
    logic                           fill_state_done;
    logic                           dump_state_done;
    logic                           state_rd;
    logic                           state_wr;
    logic [LOGIC_CH_W+WORD_W-1:0]   state_addr;

    // Sequencer side: consumes requests, drives the buffer port.
    modport master (
        input  physical_channel_en, logic_channel_index, fill_start,
               dump_start, abort, state_ready,
        output physical_channel_index, busy, fill_state_done,
               dump_state_done, state_rd, state_wr, state_addr
    );

    // Environment side: issues requests, observes the buffer port.
    modport slave (
        output physical_channel_en, logic_channel_index, fill_start,
               dump_start, abort, state_ready,
        input  physical_channel_index, busy, fill_state_done,
               dump_state_done, state_rd, state_wr, state_addr
    );
endinterface
`default_nettype wire

// File: rtl/te_state_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : te_state_xfer_ctrl
// Description : Walks every physical channel, skips disabled ones, and streams
//               a word range of each enabled channel's state block to/from
//               the state buffer (fill = read, dump = write).
// Revision    : 1.0 - initial release
// ============================================================================
module te_state_xfer_ctrl #(
    parameter int PHY_CH     = 4,
    parameter int CH_IDX_W   = 2,
    parameter int LOGIC_CH_W = 5,
    parameter int WORD_W     = 5,
    parameter int FILL_FIRST = 0,
    parameter int FILL_LAST  = 23,
    parameter int DUMP_FIRST = 6,
    parameter int DUMP_LAST  = 23,
    parameter int SKIP_ADDR  = 14
) (
    input  wire logic              clk,
    input  wire logic              rst_b,
    te_state_xfer_ctrl_if.master   bus
);

    localparam logic [CH_IDX_W-1:0] c_LAST_CH    = CH_IDX_W'(PHY_CH - 1);
    localparam logic [CH_IDX_W-1:0] c_CH_ONE     = CH_IDX_W'(1);
    localparam logic [WORD_W-1:0]   c_WA_ONE     = WORD_W'(1);
    localparam logic [WORD_W-1:0]   c_FILL_FIRST = WORD_W'(FILL_FIRST);
    localparam logic [WORD_W-1:0]   c_FILL_LAST  = WORD_W'(FILL_LAST);
    localparam logic [WORD_W-1:0]   c_DUMP_FIRST = WORD_W'(DUMP_FIRST);
    localparam logic [WORD_W-1:0]   c_DUMP_LAST  = WORD_W'(DUMP_LAST);
    localparam logic [WORD_W-1:0]   c_SKIP_ADDR  = WORD_W'(SKIP_ADDR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_XFER   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_mode,  w_mode_nxt;   // 0 = fill, 1 = dump
    logic [CH_IDX_W-1:0]     r_ch,    w_ch_nxt;
    logic [WORD_W-1:0]       r_wa,    w_wa_nxt;
    logic [LOGIC_CH_W-1:0]   r_li,    w_li_nxt;

    logic                    w_skip;
    logic                    w_adv;
    logic                    w_last_word;

    // The skipped dump word issues no access, so it never waits on the buffer.
    assign w_skip      = r_mode && (r_wa == c_SKIP_ADDR);
    assign w_adv       = bus.state_ready || w_skip;
    assign w_last_word = r_mode ? (r_wa == c_DUMP_LAST) : (r_wa == c_FILL_LAST);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_ch    <= '0;
            r_wa    <= '0;
            r_li    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_ch    <= w_ch_nxt;
            r_wa    <= w_wa_nxt;
            r_li    <= w_li_nxt;
        end
    end

    // Next-state and datapath updates; abort outranks every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_ch_nxt    = r_ch;
        w_wa_nxt    = r_wa;
        w_li_nxt    = r_li;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.fill_start || bus.dump_start) begin
                        w_state_nxt = S_SELECT;
                        w_mode_nxt  = !bus.fill_start;
                        w_ch_nxt    = '0;
                    end
                end
                S_SELECT: begin
                    if (bus.physical_channel_en[r_ch]) begin
                        w_li_nxt    = bus.logic_channel_index[r_ch*LOGIC_CH_W +: LOGIC_CH_W];
                        w_wa_nxt    = r_mode ? c_DUMP_FIRST : c_FILL_FIRST;
                        w_state_nxt = S_XFER;
                    end else if (r_ch == c_LAST_CH) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ch_nxt    = r_ch + c_CH_ONE;
                    end
                end
                S_XFER: begin
                    if (w_adv) begin
                        if (w_last_word) begin
                            if (r_ch == c_LAST_CH) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_ch_nxt    = r_ch + c_CH_ONE;
                                w_state_nxt = S_SELECT;
                            end
                        end else begin
                            w_wa_nxt = r_wa + c_WA_ONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy                   = (r_state != S_IDLE);
    assign bus.physical_channel_index = r_ch;
    assign bus.state_addr             = {r_li, r_wa};
    assign bus.state_rd               = (r_state == S_XFER) && !r_mode;
    assign bus.state_wr               = (r_state == S_XFER) && r_mode && !w_skip;
    assign bus.fill_state_done        = (r_state == S_DONE) && !r_mode;
    assign bus.dump_state_done        = (r_state == S_DONE) && r_mode;

endmodule
`default_nettype wire

// File: tb/tb_te_state_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_te_state_xfer_ctrl
// Description : Directed scoreboard bench for the state fill/dump sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_te_state_xfer_ctrl;

    localparam int PHY_CH     = 4;
    localparam int CH_IDX_W   = 2;
    localparam int LOGIC_CH_W = 5;
    localparam int WORD_W     = 5;

    // Event kinds held in the scoreboard.
    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_FDON = 2;
    localparam int K_DDON = 3;

    typedef struct {
        int kind;
        int addr;
        int lbl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0     = 0;
    int   rdy_pat = 0;
    exp_t q[$];

    te_state_xfer_ctrl_if #(
        .PHY_CH(PHY_CH), .CH_IDX_W(CH_IDX_W),
        .LOGIC_CH_W(LOGIC_CH_W), .WORD_W(WORD_W)
    ) bus ();

    te_state_xfer_ctrl dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time-stamp done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern: 1 then two stalls, repeating from the first XFER cycle.
    function automatic logic rdy_fn(input int pat, input int l);
        if (pat == 0 || l < 2) return 1'b1;
        return ((l - 2) % 3) == 0;
    endfunction

    // Drive state_ready for the upcoming cycle.
    always @(posedge clk) begin
        #1;
        bus.state_ready = rdy_fn(rdy_pat, cyc - t0);
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic void push(input int k, input int a, input int l);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.lbl  = l;
        q.push_back(e);
    endfunction

    function automatic void push_fill_ch(input int li);
        for (int w = 0; w <= 23; w++) push(K_RD, li * 32 + w, 0);
    endfunction

    function automatic void push_dump_ch(input int li, input int last_w);
        for (int w = 6; w <= last_w; w++)
            if (w != 14) push(K_WR, li * 32 + w, 0);
    endfunction

    // Monitor: every accepted access and done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (bus.state_rd || bus.state_wr) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access got addr %0d expected none", bus.state_addr);
                end else if (bus.state_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("acc_kind", bus.state_wr ? K_WR : K_RD, e.kind);
                    chk("acc_addr", int'(bus.state_addr), e.addr);
                end else begin
                    chk("stall_hold_addr", int'(bus.state_addr), q[0].addr);
                end
            end
            if (bus.fill_state_done || bus.dump_state_done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done got cycle %0d expected none", cyc - t0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_kind", bus.dump_state_done ? K_DDON : K_FDON, e.kind);
                    chk("done_cycle", cyc - t0, e.lbl);
                end
            end
        end
    end

    // Issue a one-cycle start; returns one tick into cycle E+1.
    task automatic start(input logic f, input logic d);
        @(posedge clk); #1;
        t0 = cyc;
        bus.fill_start = f;
        bus.dump_start = d;
        @(posedge clk); #1;
        bus.fill_start = 1'b0;
        bus.dump_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(bus.busy), 0);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int t;
        rst_b = 1'b0;
        bus.physical_channel_en = 4'b1111;
        bus.logic_channel_index = {5'd31, 5'd0, 5'd7, 5'd3};
        bus.fill_start  = 1'b0;
        bus.dump_start  = 1'b0;
        bus.abort       = 1'b0;
        bus.state_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rdwr", int'({bus.state_rd, bus.state_wr}), 0);
        chk("rst_addr", int'(bus.state_addr), 0);
        chk("rst_done", int'({bus.fill_state_done, bus.dump_state_done}), 0);
        chk("rst_ch", int'(bus.physical_channel_index), 0);
        rst_b = 1'b1;

        // Fill, all channels enabled.
        for (int c = 0; c < 4; c++) push_fill_ch(c == 0 ? 3 : c == 1 ? 7 : c == 2 ? 0 : 31);
        push(K_FDON, 0, 101);
        start(1'b1, 1'b0);
        @(negedge clk);
        chk("select_ch0_busy", int'(bus.busy), 1);
        wait_idle(400);

        // Dump, channels 1 and 3 only.
        bus.physical_channel_en = 4'b1010;
        push_dump_ch(7, 23);
        push_dump_ch(31, 23);
        push(K_DDON, 0, 41);
        start(1'b0, 1'b1);
        wait_idle(400);

        // No channel enabled.
        bus.physical_channel_en = 4'b0000;
        push(K_FDON, 0, 5);
        start(1'b1, 1'b0);
        @(negedge clk);
        chk("none_busy_e1", int'(bus.busy), 1);
        repeat (3) @(negedge clk);
        chk("none_busy_e4", int'(bus.busy), 1);
        wait_idle(50);

        // Fill channel 0 with a stalling buffer.
        bus.physical_channel_en = 4'b0001;
        rdy_pat = 1;
        push_fill_ch(3);
        t = 2;
        for (int w = 0; w < 24; w++) begin
            while (!rdy_fn(1, t)) t++;
            t++;
        end
        push(K_FDON, 0, t + 3);
        start(1'b1, 1'b0);
        wait_idle(400);
        rdy_pat = 0;

        // Dump aborted on the 5th XFER cycle of channel 1.
        bus.physical_channel_en = 4'b1111;
        push_dump_ch(3, 23);
        push_dump_ch(7, 10);
        start(1'b0, 1'b1);
        repeat (24) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_wr", int'(bus.state_wr), 0);
        wait_idle(20);

        // Fill after abort restarts at channel 0.
        bus.physical_channel_en = 4'b0001;
        push_fill_ch(3);
        push(K_FDON, 0, 29);
        start(1'b1, 1'b0);
        @(negedge clk);
        chk("restart_ch", int'(bus.physical_channel_index), 0);
        wait_idle(100);

        // Both starts at once selects fill; starts while busy are ignored.
        push_fill_ch(3);
        push(K_FDON, 0, 29);
        start(1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.fill_start = 1'b1;
        bus.dump_start = 1'b1;
        @(posedge clk); #1;
        bus.fill_start = 1'b0;
        bus.dump_start = 1'b0;
        wait_idle(100);

        // Abort in IDLE overrides a simultaneous start.
        @(posedge clk); #1;
        bus.fill_start = 1'b1;
        bus.abort      = 1'b1;
        @(posedge clk); #1;
        bus.fill_start = 1'b0;
        bus.abort      = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", int'(bus.busy), 0);
        wait_idle(10);

        // Reset in the middle of a dump.
        push_dump_ch(3, 13);
        start(1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1 rst_b = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_rdwr", int'({bus.state_rd, bus.state_wr}), 0);
        chk("mid_rst_addr", int'(bus.state_addr), 0);
        chk("mid_rst_ch", int'(bus.physical_channel_index), 0);
        wait_idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
